// File: rtl/contador_m_updown.sv
// contador_m_updown -- modulo-M up/down counter with 74x163-style enables.
//
// Counts modulo M (never modulo 2**W), so Q always stays in 0..M-1.
// Priority on each rising clock edge: zera (clear), then ~ld (parallel load,
// clamped to M-1), then ent&enp (count in direction 'up'), else hold.
//
// Optional build macro: CONTADOR_M_SAT_EN
//   undefined (default): the count wraps at the terminal value and 'wrap'
//                        pulses for one cycle after each wrapping edge.
//   defined            : the count saturates at M-1 (up) or 0 (down) and
//                        'wrap' is constant 0.
//
// Parameters:
//   W  counter width in bits (W >= 2)
//   M  counting modulus (2 <= M <= 2**W)
//
// Ports:
//   clock  rising-edge clock
//   clr    asynchronous active-low reset (Q=0, wrap=0)
//   zera   synchronous clear, active-high
//   ld     synchronous parallel load, active-low
//   ent    count enable T; also gates rco
//   enp    count enable P
//   up     direction, 1 = up, 0 = down
//   D      parallel load value
//   Q      registered count value
//   rco    combinational ripple carry: ent AND Q at terminal value for 'up'
//   meio   combinational flag: Q == M/2
//   wrap   registered one-cycle pulse after a wrapping edge
module contador_m_updown #(
  parameter int W = 4,
  parameter int M = 16
) (
  input  logic         clock,
  input  logic         clr,
  input  logic         zera,
  input  logic         ld,
  input  logic         ent,
  input  logic         enp,
  input  logic         up,
  input  logic [W-1:0] D,
  output logic [W-1:0] Q,
  output logic         rco,
  output logic         meio,
  output logic         wrap
);

  // M may equal 2**W, which does not fit in W bits; the load comparison is
  // done one bit wider so that every D is below M in that case.
  localparam logic [W-1:0] QMAX  = W'(M - 1);
  localparam logic [W-1:0] QHALF = W'(M / 2);
  localparam logic [W:0]   MODW  = (W + 1)'(M);

  logic [W-1:0] q_reg, q_next;
  logic         wrap_reg, wrap_next;

  always_ff @(posedge clock or negedge clr) begin
    if (!clr) begin
      q_reg    <= '0;
      wrap_reg <= 1'b0;
    end else begin
      q_reg    <= q_next;
      wrap_reg <= wrap_next;
    end
  end

  always_comb begin
    q_next    = q_reg;
    wrap_next = 1'b0;
    if (zera) begin
      q_next = '0;
    end else if (!ld) begin
      // Out-of-range load values clamp to the largest legal count.
      q_next = ({1'b0, D} < MODW) ? D : QMAX;
    end else if (ent && enp) begin
      if (up) begin
        if (q_reg == QMAX) begin
`ifdef CONTADOR_M_SAT_EN
          q_next    = QMAX;
`else
          q_next    = '0;
          wrap_next = 1'b1;
`endif
        end else begin
          q_next = q_reg + W'(1);
        end
      end else begin
        if (q_reg == '0) begin
`ifdef CONTADOR_M_SAT_EN
          q_next    = '0;
`else
          q_next    = QMAX;
          wrap_next = 1'b1;
`endif
        end else begin
          q_next = q_reg - W'(1);
        end
      end
    end
  end

  assign Q    = q_reg;
  assign wrap = wrap_reg;
  // Terminal value depends on the live 'up' input, so rco follows a
  // direction change immediately rather than on the next edge.
  assign rco  = ent & (up ? (q_reg == QMAX) : (q_reg == '0));
  assign meio = (q_reg == QHALF);

endmodule

// File: tb/tb_contador_m_updown.sv
// tb_contador_m_updown -- directed self-checking bench for contador_m_updown.
// Instance 'dut_a' is W=4, M=10; instance 'dut_b' is W=4, M=16. Both share
// the same inputs; each stage checks only the instance it exercises.
// Expectations follow the CONTADOR_M_SAT_EN setting of the build.
module tb_contador_m_updown;

  logic       clock = 1'b0;
  logic       clr, zera, ld, ent, enp, up;
  logic [3:0] D;
  logic [3:0] qa, qb;
  logic       rco_a, meio_a, wrap_a;
  logic       rco_b, meio_b, wrap_b;

  int checks = 0;
  int errors = 0;

`ifdef CONTADOR_M_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  contador_m_updown #(.W(4), .M(10)) dut_a (
    .clock(clock), .clr(clr), .zera(zera), .ld(ld), .ent(ent), .enp(enp),
    .up(up), .D(D), .Q(qa), .rco(rco_a), .meio(meio_a), .wrap(wrap_a)
  );

  contador_m_updown #(.W(4), .M(16)) dut_b (
    .clock(clock), .clr(clr), .zera(zera), .ld(ld), .ent(ent), .enp(enp),
    .up(up), .D(D), .Q(qb), .rco(rco_b), .meio(meio_b), .wrap(wrap_b)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  // One rising edge, then settle to the falling edge for sampling.
  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    int qe;
    clr = 1'b0; zera = 1'b0; ld = 1'b1; ent = 1'b1; enp = 1'b1; up = 1'b1;
    D = 4'd0;
    #1;
    check("rst_q", qa, 0);
    check("rst_wrap", wrap_a, 0);
    check("rst_rco_up", rco_a, 0);
    check("rst_meio", meio_a, 0);
    up = 1'b0;
    #1;
    check("rst_rco_down", rco_a, 1);
    up = 1'b1;

    // Count up from reset for 15 edges.
    @(negedge clock);
    clr = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      step();
      qe = SAT ? ((i < 9) ? i : 9) : (i % 10);
      check($sformatf("up%0d_q", i), qa, qe);
      check($sformatf("up%0d_wrap", i), wrap_a, (!SAT && i == 10) ? 1 : 0);
      check($sformatf("up%0d_rco", i), rco_a, (qe == 9) ? 1 : 0);
      check($sformatf("up%0d_meio", i), meio_a, (qe == 5) ? 1 : 0);
    end

    // Clear, then one down-count edge from 0.
    zera = 1'b1;
    step();
    check("zera_q", qa, 0);
    check("zera_wrap", wrap_a, 0);
    zera = 1'b0; up = 1'b0;
    step();
    check("down0_q", qa, SAT ? 0 : 9);
    check("down0_wrap", wrap_a, SAT ? 0 : 1);
    check("down0_rco", rco_a, SAT ? 1 : 0);
    ent = 1'b0;
    #1;
    check("ent0_rco", rco_a, 0);
    step();
    check("ent0_hold_q", qa, SAT ? 0 : 9);
    check("ent0_wrap", wrap_a, 0);

    // Parallel load with clamping, and clear over load.
    ent = 1'b1; ld = 1'b0; D = 4'd7;
    step();
    check("ld7_q", qa, 7);
    D = 4'd12;
    step();
    check("ld12_q", qa, 9);
    D = 4'd10;
    step();
    check("ld10_q", qa, 9);
    zera = 1'b1; D = 4'd7;
    step();
    check("zera_over_ld_q", qa, 0);
    zera = 1'b0; D = 4'd3; up = 1'b1;
    step();
    check("ld_over_count_q", qa, 3);
    ld = 1'b1; enp = 1'b0;
    step();
    check("enp0_hold_q", qa, 3);
    check("enp0_wrap", wrap_a, 0);
    enp = 1'b1;
    step();
    check("resume_q", qa, 4);

    // Asynchronous reset mid-count.
    ld = 1'b0; D = 4'd5;
    step();
    check("ld5_q", qa, 5);
    ld = 1'b1;
    clr = 1'b0;
    #1;
    check("clr_async_q", qa, 0);
    check("clr_async_wrap", wrap_a, 0);
    step();
    check("clr_edge_q", qa, 0);
    clr = 1'b1;
    step();
    check("clr_release_q", qa, 1);

    // Asynchronous reset kills a pending wrap pulse.
    ld = 1'b0; D = 4'd9;
    step();
    ld = 1'b1;
    step();
    check("wrap_pre_q", qa, SAT ? 9 : 0);
    check("wrap_pre", wrap_a, SAT ? 0 : 1);
    clr = 1'b0;
    #1;
    check("clr_wrap", wrap_a, 0);
    check("clr_wrap_q", qa, 0);
    clr = 1'b1;

    // M=16 instance: direction toggled every edge from 8.
    @(negedge clock);
    ld = 1'b0; D = 4'd8;
    step();
    check("b_ld8_q", qb, 8);
    check("b_ld8_meio", meio_b, 1);
    ld = 1'b1;
    for (int i = 0; i < 4; i++) begin
      up = (i % 2 == 0);
      step();
      check($sformatf("b_tog%0d_q", i), qb, (i % 2 == 0) ? 9 : 8);
      check($sformatf("b_tog%0d_meio", i), meio_b, (i % 2 == 0) ? 0 : 1);
    end

    // M=2**W boundary: load 15, count up once.
    ld = 1'b0; D = 4'd15; up = 1'b1;
    step();
    check("b_ld15_q", qb, 15);
    check("b_ld15_rco", rco_b, 1);
    check("a_ld15_q", qa, 9);
    ld = 1'b1;
    step();
    check("b_wrap_q", qb, SAT ? 15 : 0);
    check("b_wrap", wrap_b, SAT ? 0 : 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
